gate_unit_arbiter: RTL and testbench
====================================

Name: gate_unit_arbiter

Overview:
- Shares one registered 2-input bitwise logic unit (AND/OR/XOR/NAND) between NREQ requesters.
- Round-robin arbitration. A 3-state controller sequences grant, evaluation and completion.
- Sits between lab stimulus sources and the shared gate datapath.
- One operation is in flight at a time; each requester sees a req/done handshake.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand and result width in bits.
- PTR_W, 2, pointer width; must satisfy 2**PTR_W >= NREQ.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request level; bit i belongs to requester i.
- a_bus  input  NREQ*WIDTH  operand A; slice i is [i*WIDTH +: WIDTH].
- b_bus  input  NREQ*WIDTH  operand B, same slicing as a_bus.
- op_bus  input  NREQ*2  per-requester opcode: 00 AND, 01 OR, 10 XOR, 11 NAND.
- gnt  output  NREQ  one-hot grant; held for the whole EVAL state.
- done  output  NREQ  one-hot, single-cycle completion pulse.
- result  output  WIDTH  registered result; valid while done is nonzero.
- busy  output  1  high when state != IDLE.
- grant_cnt  output  16  completed-operation count (optional feature).

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous and active-low.
  - While rst_n=0: state=IDLE, gnt=0, done=0, result=0, busy=0, pointer=0, grant_cnt=0.
  - Reset asserted mid-operation aborts it. No done pulse is issued and the operation is lost.
- States:
  - IDLE: if req != 0, select the winner and go to EVAL. Otherwise stay in IDLE.
  - EVAL: gnt[winner]=1, busy=1. Latch the winner's operands and opcode into the result register. Next state is RESP.
  - RESP: done[winner]=1 for exactly one cycle; result holds the computed value; gnt=0. Pointer becomes (winner+1) mod NREQ. Next state is IDLE.
- Arbitration: round-robin. Search starts at the pointer and ascends with wrap-around. The first set req bit wins.
- Latency: req sampled in IDLE at edge t -> gnt visible after edge t -> done after edge t+1. Minimum issue interval is 3 cycles per operation.
- Operand capture: operands are sampled only at the EVAL edge. Changes to a_bus/b_bus/op_bus at any other time are ignored.
- Handshake:
  - A requester holds req until it sees done.
  - A requester must drop req in the cycle after done if it has no new operation.
  - If req stays high, the requester competes again, but behind the others because the pointer has passed it.
- Requests that drop: req going low during EVAL or RESP does not cancel the operation; it completes.
- Width rule: result is exactly WIDTH bits. NAND is the bitwise inverse of AND over WIDTH bits.
- Simultaneous requests: all bits set with pointer=p grants p, then p+1, and so on. No requester waits more than NREQ operations.
- Pointer boundary: a pointer of NREQ-1 wraps to 0 after service. Pointer values >= NREQ cannot occur.

Optional Feature:
- Macro: GATE_ARB_GRANT_CNT_EN.
- Defined: grant_cnt increments by 1 in every RESP cycle. It wraps from 16'hFFFF to 0 and is cleared by reset.
- Undefined: grant_cnt is tied to 16'h0000 and no counter register is built.

Test Plan:
- Reset: assert rst_n=0 mid-EVAL, then release -> gnt=0, done=0, result=8'h00, busy=0. The next grant goes to the lowest set req bit from pointer 0.
- Single request: req=4'b0001, a=8'hF0, b=8'h3C, op=00 -> gnt=4'b0001 one cycle later, then done=4'b0001 and result=8'h30. busy is high for 2 cycles.
- Opcode sweep on requester 2 with a=8'hAA, b=8'h0F:
  - OR gives 8'hAF.
  - XOR gives 8'hA5.
  - NAND gives 8'hF5.
- Fairness: req=4'b1111 held for 12 operations -> done order 0,1,2,3,0,1,2,3,0,1,2,3. No requester is granted twice before all others are granted once.
- Wrap and race: pointer=3, req=4'b1001 -> requester 3 is served first, then requester 0. Operands changed during RESP do not alter the result just issued.
- GATE_ARB_GRANT_CNT_EN defined: 5 completions -> grant_cnt=5. Forcing the count to 16'hFFFF and completing one more operation gives 0. With the macro undefined, grant_cnt stays 0 throughout.

Source files
------------

// File: rtl/gate_unit_arbiter.sv
// gate_unit_arbiter
//   Shares one registered 2-input bitwise logic unit (AND/OR/XOR/NAND) among
//   NREQ requesters. Requesters are picked round-robin, and one operation is in
//   flight at a time. A three-state controller runs each operation:
//     IDLE -> EVAL: pick the winner.
//     EVAL -> RESP: grant is shown and the winner's operands are evaluated.
//     RESP -> IDLE: done pulses and the pointer moves past the winner.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        per-requester request level (bit i = requester i)
//   a_bus      operand A, slice i = [i*WIDTH +: WIDTH]
//   b_bus      operand B, same slicing
//   op_bus     opcode, slice i = [i*2 +: 2]: 00 AND, 01 OR, 10 XOR, 11 NAND
//   gnt        one-hot grant, high for the whole EVAL state
//   done       one-hot single-cycle completion pulse (RESP state)
//   result     registered result, valid while done is nonzero
//   busy       state != IDLE
//   grant_cnt  completed-operation count
//
// Configuration macro
//   GATE_ARB_GRANT_CNT_EN: when defined, builds a 16-bit wrapping counter of
//   completed operations. When undefined, grant_cnt is tied to zero.

module gate_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_bus,
  input  logic [NREQ*WIDTH-1:0] b_bus,
  input  logic [NREQ*2-1:0]     op_bus,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      result,
  output logic                  busy,
  output logic [15:0]           grant_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // Round-robin pick. Scan upward from the pointer and wrap past NREQ-1.
  // The first requester found wins.
  logic [PTR_W-1:0]   pick;
  logic               found;
  int                 idx;

  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
  end

  // Operand mux for the latched winner.
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] gate_out;

  assign a_sel  = a_bus[win_q*WIDTH +: WIDTH];
  assign b_sel  = b_bus[win_q*WIDTH +: WIDTH];
  assign op_sel = op_bus[win_q*2 +: 2];

  always_comb begin
    case (op_sel)
      2'b00:   gate_out = a_sel & b_sel;
      2'b01:   gate_out = a_sel | b_sel;
      2'b10:   gate_out = a_sel ^ b_sel;
      default: gate_out = ~(a_sel & b_sel);
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          win_d   = pick;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        // Operands are sampled only on this edge. Later changes to the
        // requester's buses cannot disturb the result being returned.
        result_d = gate_out;
        state_d  = S_RESP;
      end
      S_RESP: begin
        // Move past the winner so it queues behind everyone else.
        ptr_d   = (win_q == PTR_W'(NREQ-1)) ? '0 : win_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      result_q <= result_d;
    end
  end

  logic [NREQ-1:0] win_onehot;
  assign win_onehot = NREQ'(1) << win_q;

  assign gnt    = (state_q == S_EVAL) ? win_onehot : '0;
  assign done   = (state_q == S_RESP) ? win_onehot : '0;
  assign busy   = (state_q != S_IDLE);
  assign result = result_q;

`ifdef GATE_ARB_GRANT_CNT_EN
  logic [15:0] grant_cnt_q;

  // Count one per RESP cycle, which is one per completed operation.
  // The counter wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                grant_cnt_q <= 16'h0000;
    else if (state_q == S_RESP) grant_cnt_q <= grant_cnt_q + 16'd1;
  end

  assign grant_cnt = grant_cnt_q;
`else
  assign grant_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed bench for gate_unit_arbiter with a cycle-level behavioural model.
// Each cycle the model is checked against the DUT. Literal checks pin the model.
module tb_gate_unit_arbiter;
  localparam int NREQ = 4, WIDTH = 8, PTR_W = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] a_bus = '0, b_bus = '0;
  logic [NREQ*2-1:0]     op_bus = '0;
  logic [NREQ-1:0]       gnt, done;
  logic [WIDTH-1:0]      result;
  logic                  busy;
  logic [15:0]           grant_cnt;

  gate_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .op_bus(op_bus), .gnt(gnt), .done(done), .result(result), .busy(busy),
    .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = waiting, 1 = operation granted, 2 = completing.
  int          m_phase, m_win, m_ptr;
  logic [7:0]  m_res;
  logic [15:0] m_cnt;

  function automatic logic [7:0] gate_f(logic [7:0] a, logic [7:0] b, logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic int pick_f(logic [NREQ-1:0] r, int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_win = 0; m_ptr = 0; m_res = '0; m_cnt = '0;
    end else begin
      case (m_phase)
        0: if (req != '0) begin m_win = pick_f(req, m_ptr); m_phase = 1; end
        1: begin
          m_res = gate_f(a_bus[m_win*WIDTH +: WIDTH], b_bus[m_win*WIDTH +: WIDTH],
                         op_bus[m_win*2 +: 2]);
          m_phase = 2;
        end
        default: begin m_ptr = (m_win + 1) % NREQ; m_cnt = m_cnt + 16'd1; m_phase = 0; end
      endcase
    end
  end

  // Per-cycle comparison against the model.
  logic [NREQ-1:0] e_gnt, e_done;
  logic [15:0]     e_cnt;
  always @(negedge clk) begin
    if (rst_n) begin
      e_gnt  = (m_phase == 1) ? NREQ'(1 << m_win) : '0;
      e_done = (m_phase == 2) ? NREQ'(1 << m_win) : '0;
`ifdef GATE_ARB_GRANT_CNT_EN
      e_cnt = m_cnt;
`else
      e_cnt = 16'h0000;
`endif
      checks++;
      if (gnt !== e_gnt || done !== e_done || result !== m_res ||
          busy !== (m_phase != 0) || grant_cnt !== e_cnt) begin
        errors++;
        $display("FAIL model_cmp t=%0t gnt=%b/%b done=%b/%b result=%h/%h busy=%b/%b cnt=%h/%h",
                 $time, gnt, e_gnt, done, e_done, result, m_res, busy, m_phase != 0,
                 grant_cnt, e_cnt);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Wait for a done pulse, sampling on negedges. Return the winner index,
  // the result, and the number of busy cycles seen up to and including done.
  task automatic wait_done(output int idx, output logic [7:0] res, output int bcnt);
    idx = -1; res = '0; bcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done != '0) begin
        for (int i = 0; i < NREQ; i++) if (done[i]) idx = i;
        res = result;
        return;
      end
    end
    errors++;
    $display("FAIL wait_done timeout actual=no_done expected=done");
  endtask

  function automatic void set_ops(int i, logic [7:0] a, logic [7:0] b, logic [1:0] op);
    a_bus[i*WIDTH +: WIDTH] = a;
    b_bus[i*WIDTH +: WIDTH] = b;
    op_bus[i*2 +: 2]        = op;
  endfunction

  int         w, bc;
  logic [7:0] r;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_result", 32'(result), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_cnt", 32'(grant_cnt), 0);
    @(negedge clk); rst_n = 1'b1;

    // Fairness: all requesters held high for 12 operations.
    for (int i = 0; i < NREQ; i++) set_ops(i, 8'(8'h11 * (i + 1)), 8'h5A, 2'(i));
    req = 4'b1111;
    for (int n = 0; n < 12; n++) begin
      wait_done(w, r, bc);
      chk("fair_order", 32'(w), 32'(n % 4));
    end
    req = '0;

    // Single request from requester 0.
    @(negedge clk);
    set_ops(0, 8'hF0, 8'h3C, 2'b00);
    req = 4'b0001;
    @(negedge clk);
    chk("single_gnt", 32'(gnt), 32'h1);
    wait_done(w, r, bc);
    bc++;   // the grant cycle above was already a busy cycle
    chk("single_idx", 32'(w), 0);
    chk("single_result", 32'(r), 32'h30);
    chk("single_busy_cycles", 32'(bc), 2);
    req = '0;

    // Opcode sweep on requester 2.
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      set_ops(2, 8'hAA, 8'h0F, 2'(k));
      req = 4'b0100;
      wait_done(w, r, bc);
      chk("sweep_idx", 32'(w), 2);
      chk("sweep_result", 32'(r), (k == 1) ? 32'hAF : (k == 2) ? 32'hA5 : 32'hF5);
      req = '0;
    end

    // Wrap and race: pointer is 3, so requester 3 goes before requester 0.
    @(negedge clk);
    set_ops(3, 8'hFF, 8'h0F, 2'b00);
    set_ops(0, 8'h12, 8'h34, 2'b01);
    req = 4'b1001;
    wait_done(w, r, bc);
    chk("wrap_first", 32'(w), 3);
    chk("wrap_first_result", 32'(r), 32'h0F);
    set_ops(3, 8'h00, 8'h00, 2'b01);   // operands change during RESP
    req = 4'b0001;
    #1 chk("race_hold", 32'(result), 32'h0F);
    wait_done(w, r, bc);
    chk("wrap_second", 32'(w), 0);
    chk("wrap_second_result", 32'(r), 32'h36);
    req = '0;

    // Reset during EVAL aborts the operation and clears the pointer.
    @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 32'h8);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_gnt0", 32'(gnt), 0);
    chk("abort_done0", 32'(done), 0);
    chk("abort_result0", 32'(result), 0);
    chk("abort_busy0", 32'(busy), 0);
    set_ops(1, 8'h0F, 8'hF0, 2'b10);
    req = 4'b0011;
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_done(w, r, bc);
    chk("post_reset_first", 32'(w), 0);
    chk("post_reset_result", 32'(r), 32'h36);
    req = 4'b0010;
    wait_done(w, r, bc);
    chk("post_reset_second", 32'(w), 1);
    chk("post_reset_result2", 32'(r), 32'hFF);
    req = '0;

`ifdef GATE_ARB_GRANT_CNT_EN
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      req = 4'b0100;
      wait_done(w, r, bc);
      req = '0;
    end
    @(negedge clk);
    chk("cnt_five", 32'(grant_cnt), 5);
    #2;
    dut.grant_cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(negedge clk);
    req = 4'b0100;
    wait_done(w, r, bc);
    req = '0;
    @(negedge clk);
    chk("cnt_wrap", 32'(grant_cnt), 0);
`else
    @(negedge clk);
    chk("cnt_tied", 32'(grant_cnt), 0);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
